mb_scan_gen: RTL and testbench

- Parametrised successor to the fixed x/y counter datapath: generates pixel coordinates (x, y) for a whole frame, walking block by block.
- Within a block, pixels go in raster order. Block order is selectable: raster, serpentine or column-major.
- Feeds the macroblock fetch / prediction front end of the H.264 encoder through a valid/ready handshake with backpressure.

---
 rtl/mb_scan_gen.sv | 221 ++++++++++++++++++++++
 tb/tb_mb_scan_gen.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mb_scan_gen.sv
// mb_scan_gen: block-wise pixel coordinate generator for the macroblock fetch front end.
//
// Walks a whole frame one block at a time. Pixels inside a block are emitted in
// raster order; the order in which blocks are visited is selected by mode:
//   0 raster, 1 serpentine (boustrophedon over block rows), 2 column-major, 3 raster.
// Each coordinate is offered with a valid/ready handshake and advances only when
// accepted. All outputs come straight from flops.
//
// Ports:
//   clk           clock
//   rst           synchronous active-high reset (aborts a scan, no done pulse)
//   start         begin a frame scan; only sampled while idle
//   mode[1:0]     block order, latched on an accepted start
//   ready         downstream accepts the current coordinate
//   valid         x/y and flags describe a live beat
//   x, y          pixel column / row
//   blk_x, blk_y  block column / row index
//   first_in_blk  beat is pixel (0,0) of its block
//   last_in_blk   beat is pixel (BLK_W-1,BLK_H-1) of its block
//   last          beat is the final beat of the frame
//   busy          scan in progress
//   done          one-cycle pulse after the final beat is accepted
module mb_scan_gen #(
    parameter int unsigned FRAME_W = 352,
    parameter int unsigned FRAME_H = 288,
    parameter int unsigned BLK_W   = 16,
    parameter int unsigned BLK_H   = 16,
    parameter int unsigned COORD_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic               ready,
    output logic               valid,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic [COORD_W-1:0] blk_x,
    output logic [COORD_W-1:0] blk_y,
    output logic               first_in_blk,
    output logic               last_in_blk,
    output logic               last,
    output logic               busy,
    output logic               done
);

    localparam int unsigned NBX   = FRAME_W / BLK_W;
    localparam int unsigned NBY   = FRAME_H / BLK_H;
    localparam int unsigned BW_SH = $clog2(BLK_W);
    localparam int unsigned BH_SH = $clog2(BLK_H);

    localparam logic [COORD_W-1:0] BW_M1  = COORD_W'(BLK_W - 1);
    localparam logic [COORD_W-1:0] BH_M1  = COORD_W'(BLK_H - 1);
    localparam logic [COORD_W-1:0] NBX_M1 = COORD_W'(NBX - 1);
    localparam logic [COORD_W-1:0] NBY_M1 = COORD_W'(NBY - 1);

    // Serpentine ends on the left edge when it has swept an even number of block rows.
    localparam logic [COORD_W-1:0] SERP_FIN_BX = ((NBY % 2) == 0) ? '0 : NBX_M1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [1:0] MODE_RASTER = 2'd0;
    localparam logic [1:0] MODE_SERP   = 2'd1;
    localparam logic [1:0] MODE_COL    = 2'd2;

    // Scan state
    logic [0:0]         state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [COORD_W-1:0] px_q, px_d;
    logic [COORD_W-1:0] py_q, py_d;
    logic [COORD_W-1:0] bx_q, bx_d;
    logic [COORD_W-1:0] by_q, by_d;
    logic               done_d;

    // Output next values, derived from the next-state counters
    logic               run_d;
    logic [COORD_W-1:0] x_d, y_d, blk_x_d, blk_y_d;
    logic               first_d, lib_d, last_d;
    logic [COORD_W-1:0] fin_bx_d;

    // Counter / FSM next state
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        px_d    = px_q;
        py_d    = py_q;
        bx_d    = bx_q;
        by_d    = by_q;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    mode_d  = mode;
                    px_d    = '0;
                    py_d    = '0;
                    bx_d    = '0;
                    by_d    = '0;
                end
            end

            ST_RUN: begin
                if (ready) begin
                    if (last) begin
                        // Final beat accepted: fall back to idle and pulse done.
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        px_d    = '0;
                        py_d    = '0;
                        bx_d    = '0;
                        by_d    = '0;
                    end else if (px_q != BW_M1) begin
                        px_d = px_q + 1'b1;
                    end else if (py_q != BH_M1) begin
                        px_d = '0;
                        py_d = py_q + 1'b1;
                    end else begin
                        // Block finished: restart inner walk and step the block index.
                        px_d = '0;
                        py_d = '0;
                        case (mode_q)
                            MODE_SERP: begin
                                if (!by_q[0]) begin
                                    if (bx_q == NBX_M1) by_d = by_q + 1'b1;
                                    else                bx_d = bx_q + 1'b1;
                                end else begin
                                    if (bx_q == '0) by_d = by_q + 1'b1;
                                    else            bx_d = bx_q - 1'b1;
                                end
                            end
                            MODE_COL: begin
                                if (by_q == NBY_M1) begin
                                    by_d = '0;
                                    bx_d = bx_q + 1'b1;
                                end else begin
                                    by_d = by_q + 1'b1;
                                end
                            end
                            default: begin
                                if (bx_q == NBX_M1) begin
                                    bx_d = '0;
                                    by_d = by_q + 1'b1;
                                end else begin
                                    bx_d = bx_q + 1'b1;
                                end
                            end
                        endcase
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Output next values; everything is zero while idle.
    always_comb begin
        run_d    = (state_d == ST_RUN);
        fin_bx_d = (mode_d == MODE_SERP) ? SERP_FIN_BX : NBX_M1;

        x_d     = '0;
        y_d     = '0;
        blk_x_d = '0;
        blk_y_d = '0;
        first_d = 1'b0;
        lib_d   = 1'b0;
        last_d  = 1'b0;

        if (run_d) begin
            // Block sizes are powers of two, so the pixel offset fills the low bits.
            x_d     = (bx_d << BW_SH) | px_d;
            y_d     = (by_d << BH_SH) | py_d;
            blk_x_d = bx_d;
            blk_y_d = by_d;
            first_d = (px_d == '0) && (py_d == '0);
            lib_d   = (px_d == BW_M1) && (py_d == BH_M1);
            last_d  = lib_d && (bx_d == fin_bx_d) && (by_d == NBY_M1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            mode_q       <= MODE_RASTER;
            px_q         <= '0;
            py_q         <= '0;
            bx_q         <= '0;
            by_q         <= '0;
            valid        <= 1'b0;
            busy         <= 1'b0;
            x            <= '0;
            y            <= '0;
            blk_x        <= '0;
            blk_y        <= '0;
            first_in_blk <= 1'b0;
            last_in_blk  <= 1'b0;
            last         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            px_q         <= px_d;
            py_q         <= py_d;
            bx_q         <= bx_d;
            by_q         <= by_d;
            valid        <= run_d;
            busy         <= run_d;
            x            <= x_d;
            y            <= y_d;
            blk_x        <= blk_x_d;
            blk_y        <= blk_y_d;
            first_in_blk <= first_d;
            last_in_blk  <= lib_d;
            last         <= last_d;
            done         <= done_d;
        end
    end

endmodule

// File: tb/tb_mb_scan_gen.sv
module tb_mb_scan_gen;

    localparam int FW = 8;
    localparam int FH = 8;
    localparam int BW = 4;
    localparam int BH = 4;
    localparam int CW = 16;
    localparam int NBX = FW / BW;
    localparam int NBY = FH / BH;
    localparam int BEATS = FW * FH;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic [CW-1:0] bx;
        logic [CW-1:0] by;
        logic          f;
        logic          lib;
        logic          l;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic          ready = 1'b1;
    logic          valid;
    logic [CW-1:0] x, y, blk_x, blk_y;
    logic          first_in_blk, last_in_blk, last, busy, done;

    int checks = 0;
    int errors = 0;
    beat_t sb[$];
    int frame_beats = 0;
    logic done_pend = 1'b0;

    mb_scan_gen #(
        .FRAME_W(FW), .FRAME_H(FH), .BLK_W(BW), .BLK_H(BH), .COORD_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .ready(ready),
        .valid(valid), .x(x), .y(y), .blk_x(blk_x), .blk_y(blk_y),
        .first_in_blk(first_in_blk), .last_in_blk(last_in_blk), .last(last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: list the blocks in visiting order, then raster pixels within each.
    task automatic push_frame(input int m);
        int bxs[$];
        int bys[$];
        beat_t e;
        bxs.delete();
        bys.delete();
        if (m == 1) begin
            for (int r = 0; r < NBY; r++)
                for (int k = 0; k < NBX; k++) begin
                    bxs.push_back((r % 2 == 1) ? NBX - 1 - k : k);
                    bys.push_back(r);
                end
        end else if (m == 2) begin
            for (int c = 0; c < NBX; c++)
                for (int r = 0; r < NBY; r++) begin
                    bxs.push_back(c);
                    bys.push_back(r);
                end
        end else begin
            for (int r = 0; r < NBY; r++)
                for (int c = 0; c < NBX; c++) begin
                    bxs.push_back(c);
                    bys.push_back(r);
                end
        end
        for (int b = 0; b < bxs.size(); b++)
            for (int py = 0; py < BH; py++)
                for (int px = 0; px < BW; px++) begin
                    e.x   = CW'(bxs[b] * BW + px);
                    e.y   = CW'(bys[b] * BH + py);
                    e.bx  = CW'(bxs[b]);
                    e.by  = CW'(bys[b]);
                    e.f   = (px == 0) && (py == 0);
                    e.lib = (px == BW - 1) && (py == BH - 1);
                    e.l   = e.lib && (b == bxs.size() - 1);
                    sb.push_back(e);
                end
    endtask

    // Monitor: compares accepted beats against the scoreboard and tracks done.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("done", done, done_pend);
                if (done) begin
                    chk("valid_in_done", valid, 0);
                    chk("frame_beats", frame_beats, BEATS);
                    frame_beats = 0;
                end
                chk("busy_eq_valid", busy, valid);
                done_pend = 1'b0;
                if (valid && ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_empty: got beat x=%0d y=%0d expected none", x, y);
                    end else begin
                        e = sb.pop_front();
                        chk("x", x, e.x);
                        chk("y", y, e.y);
                        chk("blk_x", blk_x, e.bx);
                        chk("blk_y", blk_y, e.by);
                        chk("first_in_blk", first_in_blk, e.f);
                        chk("last_in_blk", last_in_blk, e.lib);
                        chk("last", last, e.l);
                    end
                    frame_beats++;
                    done_pend = last;
                end
            end else begin
                frame_beats = 0;
                done_pend = 1'b0;
            end
        end
    end

    task automatic issue_start(input int m);
        push_frame(m);
        start = 1'b1;
        mode = 2'(m);
        @(posedge clk);
        #1;
        start = 1'b0;
        mode = 2'(($urandom_range(0, 3)));
    endtask

    task automatic wait_done(input bit rnd_ready);
        int n = 0;
        while (!done && n < 2000) begin
            ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        ready = 1'b1;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL wait_done: got timeout expected done pulse");
        end
    endtask

    task automatic wait_xy(input int wx, input int wy);
        int n = 0;
        ready = 1'b1;
        while (!(valid && x == CW'(wx) && y == CW'(wy)) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!(valid && x == CW'(wx) && y == CW'(wy))) begin
            checks++;
            errors++;
            $display("FAIL wait_xy: got x=%0d y=%0d expected x=%0d y=%0d", x, y, wx, wy);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_last", last, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Raster, full rate; next frame started in the done cycle.
        issue_start(0);
        chk("beat0_valid", valid, 1);
        chk("beat0_first", first_in_blk, 1);
        wait_done(1'b0);
        issue_start(1);
        chk("b2b_valid", valid, 1);
        chk("b2b_x", x, 0);
        chk("b2b_y", y, 0);

        // Serpentine, column-major and mode 3 under random backpressure.
        wait_done(1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("idle_busy", busy, 0);
        issue_start(2);
        wait_done(1'b1);
        @(posedge clk);
        #1;
        issue_start(3);
        wait_done(1'b1);
        @(posedge clk);
        #1;

        // Raster with a held beat and an ignored start/mode pulse mid-scan.
        issue_start(0);
        wait_xy(1, 1);
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("hold_x", x, 1);
            chk("hold_y", y, 1);
            chk("hold_valid", valid, 1);
        end
        ready = 1'b1;
        wait_xy(2, 2);
        start = 1'b1;
        mode = 2'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        mode = 2'd0;
        wait_done(1'b0);
        @(posedge clk);
        #1;

        // Reset in the middle of a scan.
        issue_start(0);
        wait_xy(4, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_x", x, 0);
        chk("mid_rst_y", y, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        @(posedge clk);
        #1;
        chk("mid_rst_done2", done, 0);
        issue_start(0);
        chk("restart_x", x, 0);
        chk("restart_y", y, 0);
        wait_done(1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
